// File: rtl/edge_pulse_array_if.sv
`default_nettype none
// ============================================================================
// Module   : edge_pulse_array_if
// Purpose  : Bundle of trigger inputs, mode select and pulse/level outputs
//            shared between the edge pulse array and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface edge_pulse_array_if #(
  parameter int CH = 4
);
  logic [CH-1:0] trig;
  logic [1:0]    mode;
  logic [CH-1:0] pulse;
  logic [CH-1:0] level;
  logic          any_pulse;

  // User side: drives triggers and mode, observes pulses and levels.
  modport master (
    output trig,
    output mode,
    input  pulse,
    input  level,
    input  any_pulse
  );

  // Design side.
  modport slave (
    input  trig,
    input  mode,
    output pulse,
    output level,
    output any_pulse
  );
endinterface
`default_nettype wire

// File: rtl/edge_pulse_array.sv
`default_nettype none
// ============================================================================
// Module   : edge_pulse_array
// Purpose  : CH independent channels, each synchronising, debouncing and
//            turning an asynchronous trigger into one-cycle pulses on a
//            selectable edge, with optional auto-repeat while held.
// Revision : 1.0 - initial release
// ============================================================================
module edge_pulse_array #(
  parameter int CH            = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  edge_pulse_array_if.slave     io
);

  // Counter widths sized to the largest terminal value, never below 1 bit.
  localparam int c_DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int c_R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_R_W   = (c_R_MAX > 1) ? $clog2(c_R_MAX) : 1;

  localparam logic [c_DB_W-1:0] c_DB_TERM = c_DB_W'(DB_CYCLES - 1);
  localparam logic [c_R_W-1:0]  c_RD_TERM = c_R_W'(REPEAT_DELAY - 1);
  localparam logic [c_R_W-1:0]  c_RP_TERM = c_R_W'(REPEAT_PERIOD - 1);

  logic [CH-1:0] w_pulse;
  logic [CH-1:0] w_level;
  logic          w_mode_rpt;

  assign w_mode_rpt = (io.mode == 2'b11);

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DB_W-1:0]      r_cnt;
    logic [c_R_W-1:0]       r_rcnt;
    logic                   r_rep;    // set once the first (delayed) repeat has fired
    logic                   r_level;
    logic                   r_pulse;
    logic                   w_synced;
    logic                   w_flip;
    logic [c_R_W-1:0]       w_rterm;

    assign w_synced = r_sync[SYNC_STAGES-1];
    // Level flips on the edge where the disagreement has lasted DB_CYCLES samples.
    assign w_flip   = (w_synced != r_level) && (r_cnt == c_DB_TERM);
    assign w_rterm  = r_rep ? c_RP_TERM : c_RD_TERM;

    // Synchroniser, debounce counter, level, edge pulse and auto-repeat for one channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync  <= '0;
        r_cnt   <= '0;
        r_rcnt  <= '0;
        r_rep   <= 1'b0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_sync  <= {r_sync[SYNC_STAGES-2:0], io.trig[gi]};
        r_pulse <= 1'b0;

        if (w_synced == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt != c_DB_TERM) begin
          r_cnt <= r_cnt + c_DB_W'(1);
        end else begin
          r_cnt   <= '0;
          r_level <= w_synced;
        end

        if (w_flip) begin
          // Any flip restarts the repeat delay; w_synced is the new level.
          r_rcnt <= '0;
          r_rep  <= 1'b0;
          case (io.mode)
            2'b00:   r_pulse <= w_synced;
            2'b01:   r_pulse <= ~w_synced;
            2'b10:   r_pulse <= 1'b1;
            default: r_pulse <= w_synced;
          endcase
        end else if (w_mode_rpt && r_level) begin
          if (r_rcnt == w_rterm) begin
            r_pulse <= 1'b1;
            r_rcnt  <= '0;
            r_rep   <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt + c_R_W'(1);
          end
        end else begin
          // Outside a held auto-repeat the delay stays armed at zero.
          r_rcnt <= '0;
          r_rep  <= 1'b0;
        end
      end
    end

    assign w_pulse[gi] = r_pulse;
    assign w_level[gi] = r_level;
  end

  assign io.pulse     = w_pulse;
  assign io.level     = w_level;
  assign io.any_pulse = |w_pulse;

endmodule
`default_nettype wire
